// File: rtl/rr_grant_encoder.sv
// ---------------------------------------------------------------------------
// rr_grant_encoder
//   Registered round-robin arbiter. A level request vector is reduced to a
//   single granted requester, presented one-hot and binary-encoded behind a
//   valid/ready output stage. A granted entry is held under backpressure and
//   is never withdrawn. With STICKY=1 an accepted requester that keeps
//   requesting is re-granted up to MAX_BURST times in a row.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   IN_req     in   [LEN]  level requests, bit i = requester i pending
//   OUT_ready  in   consumer accepts the current grant this cycle
//   OUT_valid  out  grant register holds a valid grant
//   OUT_idxOH  out  [LEN]  one-hot grant, zero when OUT_valid=0
//   OUT_idx    out  [IW]   binary index of the grant, zero when OUT_valid=0
// ---------------------------------------------------------------------------
module rr_grant_encoder #(
    parameter int LEN       = 8,
    parameter int STICKY    = 0,
    parameter int MAX_BURST = 4,
    localparam int IW       = (LEN == 1) ? 1 : $clog2(LEN),
    localparam int BW       = (MAX_BURST <= 1) ? 1 : $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LEN-1:0]  IN_req,
    input  logic            OUT_ready,
    output logic            OUT_valid,
    output logic [LEN-1:0]  OUT_idxOH,
    output logic [IW-1:0]   OUT_idx
);

    // Binary index to one-hot conversion over LEN requesters.
    function automatic logic [LEN-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [LEN-1:0] oh;
        oh = {LEN{1'b0}};
        for (int i = 0; i < LEN; i++) begin
            if (idx == IW'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    logic [IW-1:0]  ptr_r;
    logic [BW-1:0]  burst_r;

    logic           accept_s;
    logic           load_s;
    logic           req_still_s;
    logic [BW-1:0]  burst_inc_s;
    logic           sticky_cont_s;
    logic [IW-1:0]  next_ptr_s;
    logic [BW-1:0]  next_burst_s;
    logic [IW-1:0]  search_ptr_s;
    logic [LEN-1:0] eff_req_s;
    logic           found_s;
    logic [IW-1:0]  gnt_idx_s;
    logic [LEN-1:0] gnt_oh_s;

    // Handshake decode, sticky decision and next pointer/burst values.
    always_comb begin
        accept_s      = OUT_valid && OUT_ready;
        load_s        = !OUT_valid || accept_s;
        // Held grant still requested; one-hot mask avoids indexing by OUT_idx.
        req_still_s   = |(IN_req & OUT_idxOH);
        burst_inc_s   = burst_r + BW'(1);
        sticky_cont_s = (STICKY != 0) && accept_s && req_still_s &&
                        (32'(burst_inc_s) < 32'(MAX_BURST));
        if (sticky_cont_s) begin
            next_ptr_s   = OUT_idx;
            next_burst_s = burst_inc_s;
        end else begin
            next_ptr_s   = (OUT_idx == IW'(LEN - 1)) ? {IW{1'b0}} : OUT_idx + IW'(1);
            next_burst_s = {BW{1'b0}};
        end
        // On an accept the search already starts from the updated pointer,
        // so the grant loaded in the same edge honours the new fairness order.
        search_ptr_s = accept_s ? next_ptr_s : ptr_r;
        // Masking the just-accepted requester creates the one-cycle bubble
        // that keeps a lone requester from monopolising the consumer.
        if (accept_s && !sticky_cont_s) begin
            eff_req_s = IN_req & ~OUT_idxOH;
        end else begin
            eff_req_s = IN_req;
        end
    end

    // Round-robin search: walk offsets from the far end so the closest hit
    // at or above the search pointer is the one left standing.
    always_comb begin
        int cand_v;
        found_s   = 1'b0;
        gnt_idx_s = {IW{1'b0}};
        cand_v    = 0;
        for (int i = LEN - 1; i >= 0; i--) begin
            cand_v = int'(search_ptr_s) + i;
            cand_v = (cand_v >= LEN) ? cand_v - LEN : cand_v;
            if (eff_req_s[cand_v]) begin
                found_s   = 1'b1;
                gnt_idx_s = IW'(cand_v);
            end else begin
                found_s   = found_s;
            end
        end
        gnt_oh_s = idx_to_onehot(gnt_idx_s) & {LEN{found_s}};
    end

    // Grant register with fairness pointer and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT_valid <= 1'b0;
            OUT_idxOH <= {LEN{1'b0}};
            OUT_idx   <= {IW{1'b0}};
            ptr_r     <= {IW{1'b0}};
            burst_r   <= {BW{1'b0}};
        end else if (load_s) begin
            OUT_valid <= found_s;
            OUT_idxOH <= gnt_oh_s;
            OUT_idx   <= gnt_idx_s;
            if (accept_s) begin
                ptr_r   <= next_ptr_s;
                burst_r <= next_burst_s;
            end else begin
                ptr_r   <= ptr_r;
                burst_r <= burst_r;
            end
        end else begin
            OUT_valid <= OUT_valid;
            OUT_idxOH <= OUT_idxOH;
            OUT_idx   <= OUT_idx;
            ptr_r     <= ptr_r;
            burst_r   <= burst_r;
        end
    end

    // One-hot and binary views must always agree; both are zero when idle.
    a_grant_consistent: assert property (@(posedge clk) disable iff (rst)
        $onehot0(OUT_idxOH) &&
        (OUT_valid ? (OUT_idxOH == idx_to_onehot(OUT_idx))
                   : ((OUT_idxOH == {LEN{1'b0}}) && (OUT_idx == {IW{1'b0}}))));

endmodule

// File: tb/tb_rr_grant_encoder.sv
module tb_rr_grant_encoder;

    logic       clk;
    logic       rst;

    logic [3:0] req4,  oh4,  req4s, oh4s;
    logic       rdy4,  v4,   rdy4s, v4s;
    logic [1:0] idx4,  idx4s;
    logic [4:0] req5,  oh5;
    logic       rdy5,  v5;
    logic [2:0] idx5;
    logic [0:0] req1,  oh1;
    logic       rdy1,  v1;
    logic [0:0] idx1;

    int n_checks;
    int n_errors;

    rr_grant_encoder #(.LEN(4), .STICKY(0), .MAX_BURST(4)) u_len4 (
        .clk(clk), .rst(rst), .IN_req(req4), .OUT_ready(rdy4),
        .OUT_valid(v4), .OUT_idxOH(oh4), .OUT_idx(idx4));

    rr_grant_encoder #(.LEN(4), .STICKY(1), .MAX_BURST(2)) u_len4s (
        .clk(clk), .rst(rst), .IN_req(req4s), .OUT_ready(rdy4s),
        .OUT_valid(v4s), .OUT_idxOH(oh4s), .OUT_idx(idx4s));

    rr_grant_encoder #(.LEN(5), .STICKY(0), .MAX_BURST(4)) u_len5 (
        .clk(clk), .rst(rst), .IN_req(req5), .OUT_ready(rdy5),
        .OUT_valid(v5), .OUT_idxOH(oh5), .OUT_idx(idx5));

    rr_grant_encoder #(.LEN(1), .STICKY(0), .MAX_BURST(4)) u_len1 (
        .clk(clk), .rst(rst), .IN_req(req1), .OUT_ready(rdy1),
        .OUT_valid(v1), .OUT_idxOH(oh1), .OUT_idx(idx1));

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_idx4  [6] = '{0, 1, 2, 3, 0, 1};
    int exp_oh4   [6] = '{1, 2, 4, 8, 1, 2};
    int exp_idx4s [6] = '{0, 0, 1, 1, 0, 0};
    int exp_v1    [6] = '{1, 0, 1, 0, 1, 0};
    int exp_v3    [4] = '{1, 0, 1, 0};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        req4  = 4'b1111; rdy4  = 1'b1;
        req4s = 4'b0011; rdy4s = 1'b1;
        req5  = 5'b00000; rdy5 = 1'b0;
        req1  = 1'b1;    rdy1  = 1'b1;

        // Reset state of every instance.
        #12;
        check_val("rst_v4",    32'(v4),    32'd0);
        check_val("rst_oh4",   32'(oh4),   32'd0);
        check_val("rst_idx4",  32'(idx4),  32'd0);
        check_val("rst_v4s",   32'(v4s),   32'd0);
        check_val("rst_v5",    32'(v5),    32'd0);
        check_val("rst_idx5",  32'(idx5),  32'd0);
        check_val("rst_v1",    32'(v1),    32'd0);
        check_val("rst_oh1",   32'(oh1),   32'd0);
        #1 rst = 1'b0;

        // Rotation, sticky bursts and LEN=1 bubbles, all in parallel.
        for (int c = 0; c < 6; c++) begin
            tick();
            check_val("rot_v",    32'(v4),    32'd1);
            check_val("rot_idx",  32'(idx4),  32'(exp_idx4[c]));
            check_val("rot_oh",   32'(oh4),   32'(exp_oh4[c]));
            check_val("stk_v",    32'(v4s),   32'd1);
            check_val("stk_idx",  32'(idx4s), 32'(exp_idx4s[c]));
            check_val("len1_v",   32'(v1),    32'(exp_v1[c]));
            check_val("len1_idx", 32'(idx1),  32'd0);
        end

        // Single requester without sticky: bubble every other cycle.
        req4 = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("bub_v",  32'(v4), 32'(exp_v3[c]));
            check_val("bub_idx", 32'(idx4), (exp_v3[c] == 1) ? 32'd2 : 32'd0);
            check_val("bub_oh",  32'(oh4),  (exp_v3[c] == 1) ? 32'd4 : 32'd0);
        end

        // Backpressure: grant 2 held while requests change.
        rdy4 = 1'b0;
        tick();
        check_val("bp_load_idx", 32'(idx4), 32'd2);
        check_val("bp_load_v",   32'(v4),   32'd1);
        req4 = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val("bp_hold_v",   32'(v4),   32'd1);
            check_val("bp_hold_idx", 32'(idx4), 32'd2);
            check_val("bp_hold_oh",  32'(oh4),  32'd4);
        end
        rdy4 = 1'b1;
        tick();
        check_val("bp_rel_idx", 32'(idx4), 32'd0);
        check_val("bp_rel_oh",  32'(oh4),  32'd1);
        check_val("bp_rel_v",   32'(v4),   32'd1);

        // Get grant 3 in the register, then reset asynchronously mid-cycle.
        req4 = 4'b1000;
        tick();
        check_val("pre_rst_idx", 32'(idx4), 32'd3);
        rdy4 = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_val("async_v",   32'(v4),   32'd0);
        check_val("async_oh",  32'(oh4),  32'd0);
        check_val("async_idx", 32'(idx4), 32'd0);
        #2 rst = 1'b0;
        #1;
        check_val("post_rst_lat_v", 32'(v4), 32'd0);
        tick();
        check_val("post_rst_v",   32'(v4),   32'd1);
        check_val("post_rst_idx", 32'(idx4), 32'd3);
        check_val("post_rst_oh",  32'(oh4),  32'd8);

        // LEN=5 wrap: accept 3 moves the pointer to 4, then 0 wins.
        req5 = 5'b01000;
        rdy5 = 1'b1;
        tick();
        check_val("l5_idx3", 32'(idx5), 32'd3);
        req5 = 5'b00011;
        tick();
        check_val("l5_wrap_idx", 32'(idx5), 32'd0);
        check_val("l5_wrap_oh",  32'(oh5),  32'd1);
        tick();
        check_val("l5_next_idx", 32'(idx5), 32'd1);
        check_val("l5_next_v",   32'(v5),   32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
